// File: rtl/ram_fifo_pkg.sv
// Shared types and defaults for the RAM-backed FIFO controller.
// Optional overflow flag: RAM_FIFO_CTRL_OVF_EN.
package ram_fifo_pkg;

  localparam int DATA_W_DEF = 8;
  localparam int ADDR_W_DEF = 2;

  typedef enum logic [1:0] {
    IDLE,
    FETCH,
    HOLD
  } rd_state_t;

endpackage

// File: rtl/ram_fifo_ptr.sv
// Write/read pointer pair with RAM full and nonempty flags.
// Pointers carry one extra wrap bit.
module ram_fifo_ptr
  import ram_fifo_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              inc_wr,
  input  logic              inc_rd,
  output logic [ADDR_W:0]   wp,
  output logic [ADDR_W:0]   rp,
  output logic              ram_full,
  output logic              ram_ne
);

  localparam logic [ADDR_W:0] DEPTH = (ADDR_W+1)'(2**ADDR_W);

  logic [ADDR_W:0] ram_used;

  assign ram_used = wp - rp;
  assign ram_full = (ram_used == DEPTH);
  assign ram_ne   = (ram_used != '0);

  always_ff @(posedge clk) begin
    if (reset) begin
      wp <= '0;
      rp <= '0;
    end else begin
      if (inc_wr) wp <= wp + (ADDR_W+1)'(1);
      if (inc_rd) rp <= rp + (ADDR_W+1)'(1);
    end
  end

endmodule

// File: rtl/ram_fifo_ctrl.sv
// FIFO controller in front of a dual-port RAM plus one output register.
// Define RAM_FIFO_CTRL_OVF_EN to add the ovf_sticky output.
module ram_fifo_ctrl
  import ram_fifo_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int ADDR_W = ADDR_W_DEF
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              wr_valid,
  output logic              wr_ready,
  input  logic [DATA_W-1:0] wr_data,
  output logic              rd_valid,
  input  logic              rd_ready,
  output logic [DATA_W-1:0] rd_data,
  output logic [ADDR_W:0]   count,
  output logic              ram_we_A,
  output logic [ADDR_W-1:0] ram_address_A,
  output logic [DATA_W-1:0] ram_data_in_A,
  output logic              ram_we_B,
  output logic [ADDR_W-1:0] ram_address_B,
  input  logic [DATA_W-1:0] ram_data_out_B
`ifdef RAM_FIFO_CTRL_OVF_EN
  ,
  output logic              ovf_sticky
`endif
);

  rd_state_t         state;
  logic [ADDR_W:0]   wp;
  logic [ADDR_W:0]   rp;
  logic              ram_full;
  logic              ram_ne;
  logic              wr_fire;
  logic              rd_fire;
  logic              fetch;
  logic [ADDR_W-1:0] addr_b_q;

  ram_fifo_ptr #(.ADDR_W(ADDR_W)) u_ptr (
    .clk      (clk),
    .reset    (reset),
    .inc_wr   (wr_fire),
    .inc_rd   (fetch),
    .wp       (wp),
    .rp       (rp),
    .ram_full (ram_full),
    .ram_ne   (ram_ne)
  );

  assign wr_ready = !reset && !ram_full;
  assign wr_fire  = wr_valid && wr_ready;
  assign rd_fire  = rd_valid && rd_ready;

  assign fetch = !reset && ram_ne &&
                 ((state == IDLE) ||
                  ((state == HOLD) && rd_ready));

  assign ram_we_A      = wr_fire;
  assign ram_address_A = wr_fire ? wp[ADDR_W-1:0] : '0;
  assign ram_data_in_A = wr_fire ? wr_data : '0;
  assign ram_we_B      = 1'b0;

  // Address is live during a fetch, otherwise parks on the last one.
  assign ram_address_B = reset ? '0 :
                         fetch ? rp[ADDR_W-1:0] : addr_b_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= IDLE;
      rd_valid <= 1'b0;
      rd_data  <= '0;
      count    <= '0;
      addr_b_q <= '0;
    end else begin
      unique case ({wr_fire, rd_fire})
        2'b10:   count <= count + (ADDR_W+1)'(1);
        2'b01:   count <= count - (ADDR_W+1)'(1);
        default: count <= count;
      endcase
      if (fetch) addr_b_q <= rp[ADDR_W-1:0];
      unique case (state)
        IDLE: begin
          if (fetch) state <= FETCH;
        end
        FETCH: begin
          state    <= HOLD;
          rd_valid <= 1'b1;
          rd_data  <= ram_data_out_B;
        end
        HOLD: begin
          if (rd_ready) begin
            rd_valid <= 1'b0;
            state    <= fetch ? FETCH : IDLE;
          end
        end
        default: begin
          state    <= IDLE;
          rd_valid <= 1'b0;
        end
      endcase
    end
  end

`ifdef RAM_FIFO_CTRL_OVF_EN
  always_ff @(posedge clk) begin
    if (reset) ovf_sticky <= 1'b0;
    else if (wr_valid && !wr_ready) ovf_sticky <= 1'b1;
  end
`endif

endmodule
